// File: rtl/affine_scan_sequencer.sv
// -----------------------------------------------------------------------------
// affine_scan_sequencer
//   Walks a 2D affine address pattern for each job descriptor taken from the
//   cfg stream. Every beat accepted on the addr port advances an x/y scan and
//   a stride accumulator; addr = offset + acc. A one-deep pending slot holds
//   the next descriptor so consecutive jobs run without a bubble.
//
// Ports
//   clk, rst            clock, synchronous active-high reset
//   cfg_valid/ready     descriptor handshake (ready = pending slot empty)
//   cfg_offset          base address of the job
//   cfg_x_stride        accumulator step inside a row (zero-extended)
//   cfg_y_stride        accumulator step after the last beat of a row
//   cfg_x_max/y_max     last x / y index of the scan
//   addr_valid/ready    address beat handshake
//   addr, addr_last     beat address, high on the final beat of a job
//   busy                a job is running or the pending slot is full
//   done                one-cycle pulse after the final beat is accepted
// -----------------------------------------------------------------------------
module affine_scan_sequencer #(
  parameter int AW  = 32,
  parameter int XSW = 16,
  parameter int CW  = 32
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           cfg_valid,
  output logic           cfg_ready,
  input  logic [AW-1:0]  cfg_offset,
  input  logic [XSW-1:0] cfg_x_stride,
  input  logic [AW-1:0]  cfg_y_stride,
  input  logic [CW-1:0]  cfg_x_max,
  input  logic [CW-1:0]  cfg_y_max,
  output logic           addr_valid,
  input  logic           addr_ready,
  output logic [AW-1:0]  addr,
  output logic           addr_last,
  output logic           busy,
  output logic           done
);

  typedef enum logic {IDLE, RUN} state_e;

  typedef struct packed {
    logic [AW-1:0]  offset;
    logic [XSW-1:0] xs;
    logic [AW-1:0]  ys;
    logic [CW-1:0]  xm;
    logic [CW-1:0]  ym;
  } desc_t;

  state_e        state_q, state_d;
  desc_t         act_q, act_d;
  desc_t         pend_q, pend_d;
  logic          pend_full_q, pend_full_d;
  logic [AW-1:0] acc_q, acc_d;
  logic [CW-1:0] x_q, x_d;
  logic [CW-1:0] y_q, y_d;
  logic [AW-1:0] addr_q, addr_d;
  logic          addr_valid_q, addr_valid_d;
  logic          addr_last_q, addr_last_d;
  logic          done_q, done_d;

  desc_t cfg_desc;
  desc_t start_desc;
  logic  cfg_hs;
  logic  beat;
  logic  last_beat;
  logic  start_job;

  always_comb begin
    cfg_desc.offset = cfg_offset;
    cfg_desc.xs     = cfg_x_stride;
    cfg_desc.ys     = cfg_y_stride;
    cfg_desc.xm     = cfg_x_max;
    cfg_desc.ym     = cfg_y_max;
  end

  assign cfg_hs    = cfg_valid && !pend_full_q;
  assign beat      = addr_valid_q && addr_ready;
  assign last_beat = beat && addr_last_q;

  always_comb begin
    // NOTE: every always_comb output gets a default first so no path
    // leaves it unassigned, which would otherwise infer a latch.
    state_d      = state_q;
    act_d        = act_q;
    pend_d       = pend_q;
    pend_full_d  = pend_full_q;
    acc_d        = acc_q;
    x_d          = x_q;
    y_d          = y_q;
    addr_d       = addr_q;
    addr_valid_d = addr_valid_q;
    addr_last_d  = addr_last_q;
    done_d       = last_beat;
    start_job    = 1'b0;
    start_desc   = cfg_desc;

    case (state_q)
      IDLE: begin
        if (cfg_hs) start_job = 1'b1;
      end
      RUN: begin
        // A descriptor arriving together with the final beat of a job with
        // nothing pending becomes the next active job directly.
        if (cfg_hs && !last_beat) begin
          pend_d      = cfg_desc;
          pend_full_d = 1'b1;
        end
        if (last_beat) begin
          if (pend_full_q) begin
            start_job   = 1'b1;
            start_desc  = pend_q;
            pend_full_d = 1'b0;
          end else if (cfg_hs) begin
            start_job = 1'b1;
          end else begin
            state_d      = IDLE;
            addr_valid_d = 1'b0;
            addr_last_d  = 1'b0;
          end
        end else if (beat) begin
          if (x_q != act_q.xm) begin
            x_d   = x_q + CW'(1);
            acc_d = acc_q + AW'(act_q.xs);
          end else begin
            x_d   = '0;
            y_d   = y_q + CW'(1);
            acc_d = acc_q + act_q.ys;
          end
          addr_d      = act_q.offset + acc_d;
          addr_last_d = (x_d == act_q.xm) && (y_d == act_q.ym);
        end
      end
      default: state_d = IDLE;
    endcase

    if (start_job) begin
      state_d      = RUN;
      act_d        = start_desc;
      acc_d        = '0;
      x_d          = '0;
      y_d          = '0;
      addr_d       = start_desc.offset;
      addr_valid_d = 1'b1;
      addr_last_d  = (start_desc.xm == '0) && (start_desc.ym == '0);
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples its pre-edge next-state value regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      pend_full_q  <= 1'b0;
      acc_q        <= '0;
      x_q          <= '0;
      y_q          <= '0;
      addr_q       <= '0;
      addr_valid_q <= 1'b0;
      addr_last_q  <= 1'b0;
      done_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      pend_full_q  <= pend_full_d;
      acc_q        <= acc_d;
      x_q          <= x_d;
      y_q          <= y_d;
      addr_q       <= addr_d;
      addr_valid_q <= addr_valid_d;
      addr_last_q  <= addr_last_d;
      done_q       <= done_d;
    end
  end

  // NOTE: descriptor storage is not reset; it is only read after a
  // handshake has written it, so a reset would just add fan-out.
  always_ff @(posedge clk) begin
    act_q  <= act_d;
    pend_q <= pend_d;
  end

  assign cfg_ready  = !pend_full_q;
  assign busy       = (state_q == RUN) || pend_full_q;
  assign addr_valid = addr_valid_q;
  assign addr       = addr_q;
  assign addr_last  = addr_last_q;
  assign done       = done_q;

endmodule

// File: tb/tb_affine_scan_sequencer.sv
// -----------------------------------------------------------------------------
// tb_affine_scan_sequencer
//   Directed jobs followed by randomized jobs with random backpressure. The
//   reference model expands each accepted descriptor into its full list of
//   beats using the closed form
//     addr(x,y) = offset + y*(x_max*x_stride + y_stride) + x*x_stride
//   and tracks the number of outstanding jobs to predict cfg_ready, busy,
//   addr_valid and done.
// -----------------------------------------------------------------------------
module tb_affine_scan_sequencer;

  localparam int AW  = 32;
  localparam int XSW = 16;
  localparam int CW  = 32;

  logic           clk;
  logic           rst;
  logic           cfg_valid;
  logic           cfg_ready;
  logic [AW-1:0]  cfg_offset;
  logic [XSW-1:0] cfg_x_stride;
  logic [AW-1:0]  cfg_y_stride;
  logic [CW-1:0]  cfg_x_max;
  logic [CW-1:0]  cfg_y_max;
  logic           addr_valid;
  logic           addr_ready;
  logic [AW-1:0]  addr;
  logic           addr_last;
  logic           busy;
  logic           done;

  affine_scan_sequencer #(.AW(AW), .XSW(XSW), .CW(CW)) dut (
    .clk          (clk),
    .rst          (rst),
    .cfg_valid    (cfg_valid),
    .cfg_ready    (cfg_ready),
    .cfg_offset   (cfg_offset),
    .cfg_x_stride (cfg_x_stride),
    .cfg_y_stride (cfg_y_stride),
    .cfg_x_max    (cfg_x_max),
    .cfg_y_max    (cfg_y_max),
    .addr_valid   (addr_valid),
    .addr_ready   (addr_ready),
    .addr         (addr),
    .addr_last    (addr_last),
    .busy         (busy),
    .done         (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // ---------------------------------------------------------------- model
  typedef struct {
    bit [31:0] addr;
    bit        last;
  } beat_t;

  beat_t     exp_q[$];
  int        outstanding = 0;
  bit        exp_done    = 1'b0;
  bit        stall_prev  = 1'b0;
  bit [31:0] prev_addr;
  bit        prev_last;

  function automatic void expand_job(bit [31:0] off, bit [31:0] xs, bit [31:0] ys,
                                     bit [31:0] xm, bit [31:0] ym);
    bit [31:0] row_span;
    beat_t     b;
    row_span = xm * xs + ys;
    for (bit [31:0] yy = 0; yy <= ym; yy++) begin
      for (bit [31:0] xx = 0; xx <= xm; xx++) begin
        b.addr = off + yy * row_span + xx * xs;
        b.last = (xx == xm) && (yy == ym);
        exp_q.push_back(b);
      end
    end
  endfunction

  // Sample between edges; events seen here take effect at the next posedge.
  always @(negedge clk) begin
    if (rst) begin
      exp_q.delete();
      outstanding = 0;
      exp_done    = 1'b0;
      stall_prev  = 1'b0;
    end else begin
      check("done", done, exp_done);
      check("addr_valid", addr_valid, outstanding > 0);
      check("cfg_ready", cfg_ready, outstanding < 2);
      check("busy", busy, outstanding > 0);
      if (stall_prev) begin
        check("hold_addr", addr, prev_addr);
        check("hold_last", addr_last, prev_last);
      end
      exp_done = 1'b0;
      if (addr_valid && addr_ready) begin
        if (exp_q.size() == 0) begin
          check("spurious_beat", 1, 0);
        end else begin
          beat_t b;
          b = exp_q.pop_front();
          check("addr", addr, b.addr);
          check("addr_last", addr_last, b.last);
          if (b.last) begin
            exp_done = 1'b1;
            outstanding--;
          end
        end
      end
      stall_prev = addr_valid && !addr_ready;
      prev_addr  = addr;
      prev_last  = addr_last;
      if (cfg_valid && cfg_ready) begin
        expand_job(cfg_offset, 32'(cfg_x_stride), cfg_y_stride, cfg_x_max, cfg_y_max);
        outstanding++;
      end
    end
  end

  // ------------------------------------------------------ ready generator
  int rdy_mode = 0;  // 0: always ready, 1: toggle, 2: random
  always @(posedge clk) begin
    #1;
    case (rdy_mode)
      0:       addr_ready = 1'b1;
      1:       addr_ready = !addr_ready;
      default: addr_ready = ($urandom_range(0, 3) != 0);
    endcase
  end

  // ---------------------------------------------------------------- tasks
  task automatic send_job(input bit [31:0] off, input bit [15:0] xs, input bit [31:0] ys,
                          input bit [31:0] xm, input bit [31:0] ym);
    int waited = 0;
    @(posedge clk);
    #1;
    cfg_valid    = 1'b1;
    cfg_offset   = off;
    cfg_x_stride = xs;
    cfg_y_stride = ys;
    cfg_x_max    = xm;
    cfg_y_max    = ym;
    forever begin
      @(negedge clk);
      if (cfg_ready) break;
      waited++;
      if (waited > 500) begin
        check("cfg_timeout", 0, 1);
        break;
      end
    end
    @(posedge clk);
    #1;
    // Scramble fields after the handshake; they must have no effect.
    cfg_valid    = 1'b0;
    cfg_offset   = $urandom;
    cfg_x_stride = 16'($urandom);
    cfg_y_stride = $urandom;
    cfg_x_max    = $urandom;
    cfg_y_max    = $urandom;
  endtask

  task automatic wait_idle();
    int cycles = 0;
    while (outstanding != 0 || exp_q.size() != 0) begin
      @(posedge clk);
      cycles++;
      if (cycles > 1000) begin
        check("idle_timeout", 0, 1);
        break;
      end
    end
    repeat (2) @(posedge clk);
  endtask

  // ----------------------------------------------------------------- main
  initial begin
    rst          = 1'b1;
    cfg_valid    = 1'b0;
    addr_ready   = 1'b0;
    cfg_offset   = '0;
    cfg_x_stride = '0;
    cfg_y_stride = '0;
    cfg_x_max    = '0;
    cfg_y_max    = '0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("rst_addr", addr, 0);
    check("rst_addr_last", addr_last, 0);
    check("rst_cfg_ready", cfg_ready, 1);

    // Basic 2x2 scan, then the same job under toggling backpressure.
    rdy_mode = 0;
    send_job(32'h100, 16'd4, 32'h40, 1, 1);
    wait_idle();
    rdy_mode = 1;
    send_job(32'h100, 16'd4, 32'h40, 1, 1);
    wait_idle();

    // Back-to-back jobs through the pending slot, column-only second job.
    rdy_mode = 0;
    send_job(32'h100, 16'd4, 32'h40, 1, 1);
    send_job(32'h1000, 16'h10, 32'd8, 0, 2);
    wait_idle();

    // Address wrap, then a single-beat job.
    send_job(32'hFFFF_FFF8, 16'd4, 32'h0, 3, 0);
    wait_idle();
    send_job(32'h20, 16'd4, 32'd8, 0, 0);
    wait_idle();

    // Reset mid-job with a descriptor pending, then restart.
    send_job(32'h100, 16'd4, 32'h40, 1, 1);
    send_job(32'h2000, 16'd2, 32'h10, 2, 2);
    @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("post_rst_valid", addr_valid, 0);
    check("post_rst_busy", busy, 0);
    check("post_rst_done", done, 0);
    send_job(32'h3000, 16'd8, 32'h100, 1, 1);
    wait_idle();

    // Random jobs with random gaps and random backpressure.
    rdy_mode = 2;
    for (int j = 0; j < 30; j++) begin
      repeat ($urandom_range(0, 3)) @(posedge clk);
      send_job($urandom, 16'($urandom), $urandom, $urandom_range(0, 3), $urandom_range(0, 3));
    end
    wait_idle();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #500_000;
    n_fail++;
    $display("FAIL watchdog: simulation did not complete in time");
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
